mem_stall_ctrl: RTL

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/mem_stall_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stall_ctrl.sv
// Purpose : MEM-stage data-memory access controller; freezes the pipeline until the access completes.
// Latency : one IDLE-detect cycle plus k REQ cycles (ack in REQ cycle k), then a single DONE cycle.
// Backpress: stall_o holds PC and pipeline registers; memory side uses a req/ack handshake with timeout.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-low reset
//   MEM_memread_i/_memwrite_i MEM-stage load/store request (both set = store)
//   MEM_addr_i, MEM_wdata_i  MEM-stage byte address and store data
//   mem_req_o, mem_write_o   registered memory request and direction
//   mem_addr_o, mem_wdata_o  latched word-aligned address and store data
//   mem_ack_i, mem_rdata_i   one-cycle completion pulse and its read data
//   stall_o                  combinational pipeline freeze
//   rdata_o                  load result towards MEM/WB
//   timeout_o, misalign_o    sticky error flags
module mem_stall_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MEM_memread_i,
    input  logic        MEM_memwrite_i,
    input  logic [31:0] MEM_addr_i,
    input  logic [31:0] MEM_wdata_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    output logic        misalign_o
);

    // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             timeout_q, timeout_d;
    logic             misalign_q, misalign_d;
    logic             stall_raw;

    logic req_any;
    logic req_aligned;

    assign req_any     = MEM_memread_i | MEM_memwrite_i;
    assign req_aligned = (MEM_addr_i[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and stall logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        misalign_d = misalign_q;
        stall_raw  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    if (req_aligned) begin
                        // Store wins when both strobes are set.
                        state_d   = ST_REQ;
                        cnt_d     = '0;
                        write_d   = MEM_memwrite_i;
                        addr_d    = MEM_addr_i;
                        wdata_d   = MEM_wdata_i;
                        stall_raw = 1'b1;
                    end else begin
                        // Misaligned access is dropped without stalling.
                        misalign_d = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                stall_raw = 1'b1;
                if (mem_ack_i) begin
                    // Ack takes priority over a coincident timeout.
                    state_d = ST_DONE;
                    if (!write_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    rdata_d   = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // Pipeline advances here; requests and acks are ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_write_o = write_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign timeout_o   = timeout_q;
    assign misalign_o  = misalign_q;
    // Gated by reset so the pipeline is not frozen while the block is held in reset.
    assign stall_o     = rst_i & stall_raw;

endmodule
